triangle_raster: RTL and testbench

TRIANGLE_RASTER -- requirements
Module: triangle_raster

---
 rtl/triangle_raster_pkg.sv | 19 +
 rtl/triangle_raster_if.sv | 16 +
 rtl/triangle_raster_edge_fn.sv | 28 ++
 rtl/triangle_raster.sv | 179 +++++++++++++++++
 tb/tb_triangle_raster.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/triangle_raster_pkg.sv
`timescale 1ns/1ps
// Shared constants and state encoding for the filled-triangle rasteriser.
package triangle_raster_pkg;

  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_TRI = 3'd1;

  localparam int SCREEN_W_DEFAULT = 160;
  localparam int SCREEN_H_DEFAULT = 120;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SETUP     = 3'd1,
    S_EDGE_INIT = 3'd2,
    S_SCAN      = 3'd3,
    S_DONE      = 3'd4
  } state_e;

endpackage

// File: rtl/triangle_raster_if.sv
`timescale 1ns/1ps
// Pixel write bus from the rasteriser to a framebuffer.
// A pixel transfers on a rising edge where pix_we and pix_ready are both 1;
// while pix_we is 1 and pix_ready is 0 the source holds every pix_* field.
interface triangle_raster_if #(
  parameter int COLOUR_WIDTH = 3
);
  logic [7:0]              pix_x;
  logic [6:0]              pix_y;
  logic [COLOUR_WIDTH-1:0] pix_colour;
  logic                    pix_we;
  logic                    pix_ready;

  modport master (output pix_x, pix_y, pix_colour, pix_we, input pix_ready);
  modport slave  (input pix_x, pix_y, pix_colour, pix_we, output pix_ready);
endinterface

// File: rtl/triangle_raster_edge_fn.sv
`timescale 1ns/1ps
// One edge function E(p) = (p1x-p0x)(py-p0y) - (p1y-p0y)(px-p0x):
// its value at the box origin plus the per-x and per-y increments.
module edge_fn #(
  parameter  int WIDTH = 32,
  localparam int EW    = 2 * WIDTH + 2
) (
  input  logic signed [WIDTH-1:0] p0x_i,
  input  logic signed [WIDTH-1:0] p0y_i,
  input  logic signed [WIDTH-1:0] p1x_i,
  input  logic signed [WIDTH-1:0] p1y_i,
  input  logic signed [WIDTH-1:0] ox_i,
  input  logic signed [WIDTH-1:0] oy_i,
  output logic signed [EW-1:0]    e0_o,
  output logic signed [EW-1:0]    step_x_o,
  output logic signed [EW-1:0]    step_y_o
);
  logic signed [EW-1:0] dx, dy, rx, ry;

  assign dx = EW'(p1x_i) - EW'(p0x_i);
  assign dy = EW'(p1y_i) - EW'(p0y_i);
  assign rx = EW'(ox_i) - EW'(p0x_i);
  assign ry = EW'(oy_i) - EW'(p0y_i);

  assign e0_o     = dx * ry - dy * rx;
  assign step_x_o = -dy;
  assign step_y_o = dx;
endmodule

// File: rtl/triangle_raster.sv
`timescale 1ns/1ps
// Filled-triangle rasteriser: bounding-box scan with incremental edge functions,
// one pixel per accepted cycle, registered pixel bus with valid/ready stall.
module triangle_raster
  import triangle_raster_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int COLOUR_WIDTH = 3,
  parameter int SCREEN_W     = SCREEN_W_DEFAULT,
  parameter int SCREEN_H     = SCREEN_H_DEFAULT
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    draw_en,
  input  logic [2:0]              opcode,
  input  logic signed [WIDTH-1:0] ax, ay, az, bx, by, bz, cx, cy, cz,
  input  logic [COLOUR_WIDTH-1:0] colour,
  output logic                    draw_done,
  output logic [7:0]              pix_x,
  output logic [6:0]              pix_y,
  output logic [COLOUR_WIDTH-1:0] pix_colour,
  output logic                    pix_we,
  input  logic                    pix_ready,
  output state_e                  dbg_state_o
);
  localparam int EW = 2 * WIDTH + 2;
  localparam logic signed [WIDTH-1:0] X_LAST = WIDTH'(SCREEN_W - 1);
  localparam logic signed [WIDTH-1:0] Y_LAST = WIDTH'(SCREEN_H - 1);

  state_e                  state_q;
  logic [2:0]              op_q;
  logic [COLOUR_WIDTH-1:0] colour_q, pix_col_q;
  logic signed [WIDTH-1:0] ax_q, ay_q, bx_q, by_q, cx_q, cy_q;
  logic [7:0]              xmin_q, xmax_q, x_q, pix_x_q;
  logic [6:0]              ymin_q, ymax_q, y_q, pix_y_q;
  logic                    done_q, pix_we_q;
  logic signed [EW-1:0]    acc_q [3];
  logic signed [EW-1:0]    row_q [3];

  logic unused_z;
  assign unused_z = ^{az, bz, cz};

  // Bounding box, clamping and degeneracy tests on the latched vertices.
  logic signed [WIDTH-1:0] lo_x, hi_x, lo_y, hi_y;
  logic signed [EW-1:0]    area;
  logic                    off_screen;
  logic [7:0]              xmin_d, xmax_d;
  logic [6:0]              ymin_d, ymax_d;

  always_comb begin
    lo_x = ax_q; hi_x = ax_q; lo_y = ay_q; hi_y = ay_q;
    if (bx_q < lo_x) lo_x = bx_q;
    if (cx_q < lo_x) lo_x = cx_q;
    if (bx_q > hi_x) hi_x = bx_q;
    if (cx_q > hi_x) hi_x = cx_q;
    if (by_q < lo_y) lo_y = by_q;
    if (cy_q < lo_y) lo_y = cy_q;
    if (by_q > hi_y) hi_y = by_q;
    if (cy_q > hi_y) hi_y = cy_q;
    off_screen = hi_x[WIDTH-1] || hi_y[WIDTH-1] || (lo_x > X_LAST) || (lo_y > Y_LAST);
    xmin_d = lo_x[WIDTH-1] ? 8'd0 : lo_x[7:0];
    ymin_d = lo_y[WIDTH-1] ? 7'd0 : lo_y[6:0];
    xmax_d = (hi_x > X_LAST) ? 8'(SCREEN_W - 1) : hi_x[7:0];
    ymax_d = (hi_y > Y_LAST) ? 7'(SCREEN_H - 1) : hi_y[6:0];
    area = (EW'(bx_q) - EW'(ax_q)) * (EW'(cy_q) - EW'(ay_q))
         - (EW'(by_q) - EW'(ay_q)) * (EW'(cx_q) - EW'(ax_q));
  end

  logic signed [WIDTH-1:0] org_x, org_y;
  logic signed [EW-1:0]    e_init [3];
  logic signed [EW-1:0]    step_x [3];
  logic signed [EW-1:0]    step_y [3];

  assign org_x = WIDTH'(xmin_q);
  assign org_y = WIDTH'(ymin_q);

  edge_fn #(.WIDTH(WIDTH)) u_edge_ab (
    .p0x_i(ax_q), .p0y_i(ay_q), .p1x_i(bx_q), .p1y_i(by_q), .ox_i(org_x), .oy_i(org_y),
    .e0_o(e_init[0]), .step_x_o(step_x[0]), .step_y_o(step_y[0]));
  edge_fn #(.WIDTH(WIDTH)) u_edge_bc (
    .p0x_i(bx_q), .p0y_i(by_q), .p1x_i(cx_q), .p1y_i(cy_q), .ox_i(org_x), .oy_i(org_y),
    .e0_o(e_init[1]), .step_x_o(step_x[1]), .step_y_o(step_y[1]));
  edge_fn #(.WIDTH(WIDTH)) u_edge_ca (
    .p0x_i(cx_q), .p0y_i(cy_q), .p1x_i(ax_q), .p1y_i(ay_q), .ox_i(org_x), .oy_i(org_y),
    .e0_o(e_init[2]), .step_x_o(step_x[2]), .step_y_o(step_y[2]));

  // Next scan position; a row wrap restarts from the row-start accumulator.
  logic                 last_x, last_y;
  logic [7:0]           x_d;
  logic [6:0]           y_d;
  logic signed [EW-1:0] e_d   [3];
  logic signed [EW-1:0] row_d [3];

  always_comb begin
    last_x = (x_q == xmax_q);
    last_y = (y_q == ymax_q);
    x_d    = last_x ? xmin_q : x_q + 8'd1;
    y_d    = last_x ? y_q + 7'd1 : y_q;
    for (int i = 0; i < 3; i++) begin
      row_d[i] = row_q[i] + step_y[i];
      e_d[i]   = last_x ? row_d[i] : acc_q[i] + step_x[i];
    end
  end

  // Inclusive test accepting either winding.
  function automatic logic is_inside(input logic signed [EW-1:0] e0, e1, e2);
    logic all_ge, all_le;
    all_ge = !e0[EW-1] && !e1[EW-1] && !e2[EW-1];
    all_le = (e0[EW-1] || e0 == '0) && (e1[EW-1] || e1 == '0) && (e2[EW-1] || e2 == '0);
    return all_ge || all_le;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      done_q    <= 1'b0;
      pix_we_q  <= 1'b0;
      pix_x_q   <= '0;
      pix_y_q   <= '0;
      pix_col_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: if (draw_en) begin
          ax_q <= ax; ay_q <= ay; bx_q <= bx; by_q <= by; cx_q <= cx; cy_q <= cy;
          colour_q <= colour;
          op_q     <= opcode;
          state_q  <= S_SETUP;
        end
        S_SETUP: if (op_q != OP_TRI || off_screen || area == '0) begin
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end else begin
          xmin_q <= xmin_d; xmax_q <= xmax_d; ymin_q <= ymin_d; ymax_q <= ymax_d;
          state_q <= S_EDGE_INIT;
        end
        S_EDGE_INIT: begin
          for (int i = 0; i < 3; i++) begin
            acc_q[i] <= e_init[i];
            row_q[i] <= e_init[i];
          end
          x_q       <= xmin_q;
          y_q       <= ymin_q;
          pix_x_q   <= xmin_q;
          pix_y_q   <= ymin_q;
          pix_col_q <= colour_q;
          pix_we_q  <= is_inside(e_init[0], e_init[1], e_init[2]);
          state_q   <= S_SCAN;
        end
        S_SCAN: if (!(pix_we_q && !pix_ready)) begin
          if (last_x && last_y) begin
            pix_we_q <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end else begin
            for (int i = 0; i < 3; i++) begin
              acc_q[i] <= e_d[i];
              if (last_x) row_q[i] <= row_d[i];
            end
            x_q      <= x_d;
            y_q      <= y_d;
            pix_x_q  <= x_d;
            pix_y_q  <= y_d;
            pix_we_q <= is_inside(e_d[0], e_d[1], e_d[2]);
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign draw_done   = done_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign pix_colour  = pix_col_q;
  assign pix_we      = pix_we_q;
  assign dbg_state_o = state_q;
endmodule

// File: tb/tb_triangle_raster.sv
`timescale 1ns/1ps
// Bench for triangle_raster: hand-checked vector table, abort/reset sequences,
// and random triangles compared pixel-by-pixel against a direct rasterising model.
module tb_triangle_raster;
  import triangle_raster_pkg::*;

  localparam int WIDTH = 32;
  localparam int CW    = 3;
  localparam int SW    = 160;
  localparam int SH    = 120;
  localparam int PW    = 8 + 7 + CW;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset, draw_en;
  logic [2:0] opcode;
  logic signed [WIDTH-1:0] v_ax, v_ay, v_az, v_bx, v_by, v_bz, v_cx, v_cy, v_cz;
  logic [CW-1:0] colour;
  logic draw_done;
  state_e dbg_state;

  always #5 clock = ~clock;

  triangle_raster_if #(.COLOUR_WIDTH(CW)) pix_if();

  triangle_raster #(.WIDTH(WIDTH), .COLOUR_WIDTH(CW), .SCREEN_W(SW), .SCREEN_H(SH)) dut (
    .clock(clock), .reset(reset), .draw_en(draw_en), .opcode(opcode),
    .ax(v_ax), .ay(v_ay), .az(v_az), .bx(v_bx), .by(v_by), .bz(v_bz),
    .cx(v_cx), .cy(v_cy), .cz(v_cz), .colour(colour), .draw_done(draw_done),
    .pix_x(pix_if.pix_x), .pix_y(pix_if.pix_y), .pix_colour(pix_if.pix_colour),
    .pix_we(pix_if.pix_we), .pix_ready(pix_if.pix_ready), .dbg_state_o(dbg_state));

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [PW-1:0] exp_q[$];

  task automatic check(input string name, input longint act, input longint req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic int min3(input int a, b, c);
    int m = a;
    if (b < m) m = b;
    if (c < m) m = c;
    return m;
  endfunction

  function automatic int max3(input int a, b, c);
    int m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  // Reference: walk the clamped box in raster order, test all three cross products.
  task automatic model(input int op, ax, ay, bx, by, cx, cy, col, output int n_box);
    int x0, x1, y0, y1;
    longint area, e1, e2, e3;
    exp_q.delete();
    n_box = 0;
    if (op != 1) return;
    x0 = min3(ax, bx, cx); x1 = max3(ax, bx, cx);
    y0 = min3(ay, by, cy); y1 = max3(ay, by, cy);
    area = longint'(bx - ax) * longint'(cy - ay) - longint'(by - ay) * longint'(cx - ax);
    if (area == 0 || x1 < 0 || y1 < 0 || x0 > SW - 1 || y0 > SH - 1) return;
    if (x0 < 0) x0 = 0;
    if (y0 < 0) y0 = 0;
    if (x1 > SW - 1) x1 = SW - 1;
    if (y1 > SH - 1) y1 = SH - 1;
    n_box = (x1 - x0 + 1) * (y1 - y0 + 1);
    for (int y = y0; y <= y1; y++) begin
      for (int x = x0; x <= x1; x++) begin
        e1 = longint'(bx - ax) * longint'(y - ay) - longint'(by - ay) * longint'(x - ax);
        e2 = longint'(cx - bx) * longint'(y - by) - longint'(cy - by) * longint'(x - bx);
        e3 = longint'(ax - cx) * longint'(y - cy) - longint'(ay - cy) * longint'(x - cx);
        if ((e1 >= 0 && e2 >= 0 && e3 >= 0) || (e1 <= 0 && e2 <= 0 && e3 <= 0))
          exp_q.push_back({8'(x), 7'(y), CW'(col)});
      end
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    draw_en = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  // ---------------- driver ----------------
  // mode 0: always ready; 1: ready low 4 cycles on the 2nd write; 2: random ready.
  task automatic run_cmd(input string tag, input int op, ax, ay, bx, by, cx, cy, col, mode,
                         output int writes, output int done_cyc);
    int n_box, n_exp, cyc, stalls, stall_left, budget, exp_done;
    logic [PW-1:0] got, want, held;
    bit holding;
    model(op, ax, ay, bx, by, cx, cy, col, n_box);
    n_exp = exp_q.size();
    budget = 4 * n_box + 40;
    writes = 0; stalls = 0; stall_left = 4; done_cyc = -1; holding = 0; held = '0;

    @(negedge clock);
    opcode = 3'(op); colour = CW'(col);
    v_ax = ax; v_ay = ay; v_bx = bx; v_by = by; v_cx = cx; v_cy = cy;
    v_az = $urandom; v_bz = $urandom; v_cz = $urandom;
    draw_en = 1'b1;
    pix_if.pix_ready = 1'b1;
    #1;
    check({tag, "_idle_no_done"}, draw_done, 0);
    check({tag, "_idle_state"}, int'(dbg_state), int'(S_IDLE));
    @(negedge clock);
    draw_en = 1'b0;
    opcode = 3'($urandom); colour = CW'($urandom);
    v_ax = $urandom; v_ay = $urandom; v_bx = $urandom;
    v_by = $urandom; v_cx = $urandom; v_cy = $urandom;

    cyc = 1;
    while (done_cyc < 0 && cyc <= budget) begin
      case (mode)
        1: begin
          pix_if.pix_ready = !(pix_if.pix_we && writes == 1 && stall_left > 0);
          if (!pix_if.pix_ready) stall_left--;
        end
        2: pix_if.pix_ready = ($urandom_range(0, 3) != 0);
        default: pix_if.pix_ready = 1'b1;
      endcase
      #1;
      got = {pix_if.pix_x, pix_if.pix_y, pix_if.pix_colour};
      if (pix_if.pix_we && !pix_if.pix_ready) begin
        stalls++;
        if (holding) check({tag, "_hold"}, {pix_if.pix_we, got}, {1'b1, held});
        else begin
          held = got;
          holding = 1;
        end
      end else if (holding) begin
        check({tag, "_release"}, {pix_if.pix_we, got}, {1'b1, held});
        holding = 0;
      end
      if (pix_if.pix_we && pix_if.pix_ready) begin
        writes++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL %s_extra_write actual=%h required=none", tag, got);
        end else begin
          want = exp_q.pop_front();
          check({tag, "_pixel"}, got, want);
        end
      end
      if (draw_done) done_cyc = cyc;
      else begin
        @(negedge clock);
        cyc++;
      end
    end
    pix_if.pix_ready = 1'b1;

    if (done_cyc < 0) begin
      check({tag, "_done_timeout"}, 0, 1);
      apply_reset();
    end else begin
      exp_done = (n_box == 0) ? 2 : 3 + n_box + stalls;
      check({tag, "_done_cycle"}, done_cyc, exp_done);
      if (mode == 1 && n_exp >= 2) check({tag, "_stall_cycles"}, stalls, 4);
    end
    check({tag, "_write_count"}, writes, n_exp);
    check({tag, "_leftover"}, exp_q.size(), 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string tag;
    int op, ax, ay, bx, by, cx, cy, col, mode;
    int exp_writes, exp_done;
  } vec_t;

  vec_t vecs[12];

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, d, seen, op, ax0, ay0;

    vecs[0]  = '{"tri_basic",   1,   0,   0,   3,   0,   0,   3, 5, 0, 10, 19};
    vecs[1]  = '{"tri_swapped", 1,   0,   0,   0,   3,   3,   0, 5, 0, 10, 19};
    vecs[2]  = '{"collinear",   1,   0,   0,   5,   5,  10,  10, 2, 0,  0,  2};
    vecs[3]  = '{"neg_corner",  1, -10, -10,   5, -10, -10,   5, 6, 0,  0, 39};
    vecs[4]  = '{"tri_stall",   1,   0,   0,   3,   0,   0,   3, 1, 1, 10, 23};
    vecs[5]  = '{"op_nop",      0,   0,   0,   3,   0,   0,   3, 1, 0,  0,  2};
    vecs[6]  = '{"op_other",    5,   0,   0,   3,   0,   0,   3, 1, 0,  0,  2};
    vecs[7]  = '{"off_right",   1, 200,  10, 210,  10, 200,  20, 7, 0,  0,  2};
    vecs[8]  = '{"tri_offset",  1,   2,   2,   4,   2,   2,   4, 3, 0,  6, 12};
    vecs[9]  = '{"point",       1,   7,   7,   7,   7,   7,   7, 4, 0,  0,  2};
    vecs[10] = '{"clip_corner", 1, 158, 118, 170, 118, 158, 130, 2, 0,  4,  7};
    vecs[11] = '{"thin",        1,  10,  10,  14,  10,  10,  11, 7, 0,  6, 13};

    reset = 1'b1; draw_en = 1'b0; opcode = '0; colour = '0;
    v_ax = '0; v_ay = '0; v_az = '0; v_bx = '0; v_by = '0; v_bz = '0;
    v_cx = '0; v_cy = '0; v_cz = '0;
    pix_if.pix_ready = 1'b1;
    repeat (3) @(negedge clock);
    check("reset_done", draw_done, 0);
    check("reset_we", pix_if.pix_we, 0);
    check("reset_x", pix_if.pix_x, 0);
    check("reset_y", pix_if.pix_y, 0);
    check("reset_colour", pix_if.pix_colour, 0);
    check("reset_state", int'(dbg_state), int'(S_IDLE));
    reset = 1'b0;

    foreach (vecs[i]) begin
      run_cmd(vecs[i].tag, vecs[i].op, vecs[i].ax, vecs[i].ay, vecs[i].bx, vecs[i].by,
              vecs[i].cx, vecs[i].cy, vecs[i].col, vecs[i].mode, w, d);
      check({vecs[i].tag, "_table_writes"}, w, vecs[i].exp_writes);
      check({vecs[i].tag, "_table_done"}, d, vecs[i].exp_done);
    end

    // Reset in the middle of a scan aborts silently.
    @(negedge clock);
    opcode = 3'd1; colour = 3'd5;
    v_ax = 0; v_ay = 0; v_bx = 3; v_by = 0; v_cx = 0; v_cy = 3;
    draw_en = 1'b1;
    @(negedge clock);
    draw_en = 1'b0;
    repeat (5) @(negedge clock);
    check("abort_in_scan", int'(dbg_state), int'(S_SCAN));
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("abort_we", pix_if.pix_we, 0);
    check("abort_state", int'(dbg_state), int'(S_IDLE));
    seen = 0;
    repeat (20) begin
      @(negedge clock);
      if (draw_done || pix_if.pix_we) seen++;
    end
    check("abort_quiet", seen, 0);
    run_cmd("abort_nop", 0, 0, 0, 0, 0, 0, 0, 0, 0, w, d);
    check("abort_nop_done", d, 2);

    // Reset wins over a simultaneous draw_en.
    @(negedge clock);
    opcode = 3'd1;
    v_ax = 0; v_ay = 0; v_bx = 3; v_by = 0; v_cx = 0; v_cy = 3;
    reset = 1'b1; draw_en = 1'b1;
    @(negedge clock);
    reset = 1'b0; draw_en = 1'b0;
    check("rst_prio_state", int'(dbg_state), int'(S_IDLE));
    seen = 0;
    repeat (6) begin
      @(negedge clock);
      if (draw_done || pix_if.pix_we || dbg_state != S_IDLE) seen++;
    end
    check("rst_prio_quiet", seen, 0);

    // Random triangles with random back-pressure.
    for (int t = 0; t < 30; t++) begin
      op  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 7)) : 1;
      ax0 = int'($urandom_range(0, 185)) - 15;
      ay0 = int'($urandom_range(0, 145)) - 15;
      run_cmd($sformatf("rnd%0d", t), op, ax0, ay0,
              ax0 + int'($urandom_range(0, 24)) - 12, ay0 + int'($urandom_range(0, 24)) - 12,
              ax0 + int'($urandom_range(0, 24)) - 12, ay0 + int'($urandom_range(0, 24)) - 12,
              int'($urandom_range(0, 7)), 2, w, d);
    end

    @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
